// File: rtl/mcu_dbg_bridge_if.sv
// rtl/mcu_dbg_bridge_if.sv - command/response bus between debug controller and MCU bridge
interface mcu_dbg_bridge_if;
  logic [31:0] d_in;
  logic [31:0] addr;
  logic        pause;
  logic        resume;
  logic        reset;
  logic        reg_rd;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic        valid;
  logic        mcu_busy;
  logic [31:0] d_rd;
  logic        error;
  logic [31:0] pc;

  modport master (
    output d_in, addr, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, valid,
    input  mcu_busy, d_rd, error, pc
  );

  modport slave (
    input  d_in, addr, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, valid,
    output mcu_busy, d_rd, error, pc
  );
endinterface

// File: rtl/mcu_dbg_bridge.sv
// rtl/mcu_dbg_bridge.sv - executes debug commands (halt/resume/reset/RF/memory) on the Otter MCU; optional DBG_AUTO_PAUSE_EN
module mcu_dbg_bridge #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mcu_dbg_bridge_if.slave         cmd,
  input  logic [31:0]             mcu_pc,
  input  logic                    mcu_instr_done,
  output logic                    mcu_halt,
  output logic                    mcu_rst,
  output logic                    dbg_own,
  output logic [4:0]              rf_addr,
  output logic [31:0]             rf_wd,
  output logic                    rf_we,
  input  logic [31:0]             rf_rdata,
  output logic [31:0]             dm_addr,
  output logic [31:0]             dm_wd,
  output logic [3:0]              dm_be,
  output logic                    dm_re,
  output logic                    dm_we,
  input  logic [31:0]             dm_rdata,
  input  logic                    mem_ack
);

  typedef enum logic [2:0] {S_RUN, S_HALT_REQ, S_HALTED, S_RST, S_REG, S_MEM} state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic        err_pend_q, err_pend_d;
  logic        auto_q, auto_d;
  logic        acc_reg_q, acc_reg_d;
  logic        acc_rd_q, acc_rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [6:0]  cmd_in;
  logic        one_hot;
  logic        is_reg_in;
  logic        is_mem_in;
  logic        run_err;
  logic        cmd_err;
  state_t      finish_state;

  // Halfword enables need an even address, a full word a word-aligned one.
  function automatic logic mem_aligned(input logic [3:0] be, input logic [1:0] a);
    case (be)
      4'b1111:                            return a == 2'b00;
      4'b0011, 4'b1100:                   return a[0] == 1'b0;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign cmd_in    = {cmd.pause, cmd.resume, cmd.reset, cmd.reg_rd, cmd.reg_wr, cmd.mem_rd, cmd.mem_wr};
  assign one_hot   = (cmd_in != 7'd0) && ((cmd_in & (cmd_in - 7'd1)) == 7'd0);
  assign is_reg_in = cmd.reg_rd | cmd.reg_wr;
  assign is_mem_in = cmd.mem_rd | cmd.mem_wr;

`ifdef DBG_AUTO_PAUSE_EN
  assign run_err = 1'b0;
`else
  assign run_err = (state_q != S_HALTED);
`endif

  assign cmd_err = !one_hot
                || ((is_reg_in || is_mem_in) && run_err)
                || (is_reg_in && (cmd.addr[31:5] != 27'd0))
                || (is_mem_in && !mem_aligned(cmd.mem_be, cmd.addr[1:0]));

  // An access started from RUN (auto-pause) lets the MCU run again afterwards.
  assign finish_state = auto_q ? S_RUN : S_HALTED;

  // Next-state, command latching and completion of every command.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    error_d    = error_q;
    err_pend_d = err_pend_q;
    auto_d     = auto_q;
    acc_reg_d  = acc_reg_q;
    acc_rd_d   = acc_rd_q;
    addr_d     = addr_q;
    din_d      = din_q;
    be_d       = be_q;
    d_rd_d     = d_rd_q;
    cnt_d      = cnt_q;
    pc_d       = mcu_pc;

    case (state_q)
      S_RUN, S_HALTED: begin
        if (busy_q) begin
          busy_d  = 1'b0;
          error_d = err_pend_q;
        end else if (cmd.valid) begin
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_pend_d = 1'b0;
          auto_d     = 1'b0;
          cnt_d      = 8'd0;
          acc_reg_d  = is_reg_in;
          acc_rd_d   = cmd.reg_rd | cmd.mem_rd;
          addr_d     = cmd.addr;
          din_d      = cmd.d_in;
          be_d       = cmd.mem_be;
          if (cmd_err) begin
            err_pend_d = 1'b1;
          end else if (cmd.reset) begin
            state_d = S_RST;
          end else if (cmd.pause) begin
            state_d = (state_q == S_RUN) ? S_HALT_REQ : S_HALTED;
          end else if (cmd.resume) begin
            state_d = S_RUN;
          end else if (state_q == S_RUN) begin
            state_d = S_HALT_REQ;
            auto_d  = 1'b1;
          end else begin
            state_d = is_reg_in ? S_REG : S_MEM;
          end
        end
      end

      S_HALT_REQ: begin
        if (mcu_instr_done) begin
          if (auto_q) begin
            state_d = acc_reg_q ? S_REG : S_MEM;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_HALTED;
            busy_d  = 1'b0;
          end
        end
      end

      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_REG: begin
        if (cnt_q == 8'd0) begin
          cnt_d = 8'd1;
        end else begin
          if (acc_rd_q) begin
            d_rd_d = (addr_q[4:0] == 5'd0) ? 32'd0 : rf_rdata;
          end
          state_d = finish_state;
          busy_d  = 1'b0;
        end
      end

      S_MEM: begin
        if (mem_ack) begin
          if (acc_rd_q) begin
            d_rd_d = dm_rdata;
          end
          state_d = finish_state;
          busy_d  = 1'b0;
        end else if (cnt_q == MEM_LAST) begin
          error_d = 1'b1;
          state_d = finish_state;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  // State and datapath registers; reset drops every strobe at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
      auto_q     <= 1'b0;
      acc_reg_q  <= 1'b0;
      acc_rd_q   <= 1'b0;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
      be_q       <= 4'd0;
      d_rd_q     <= 32'd0;
      pc_q       <= 32'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      err_pend_q <= err_pend_d;
      auto_q     <= auto_d;
      acc_reg_q  <= acc_reg_d;
      acc_rd_q   <= acc_rd_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
      d_rd_q     <= d_rd_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd.mcu_busy = busy_q;
  assign cmd.error    = error_q;
  assign cmd.d_rd     = d_rd_q;
  assign cmd.pc       = pc_q;

  assign mcu_halt = (state_q == S_HALT_REQ) || (state_q == S_HALTED) || (state_q == S_REG) || (state_q == S_MEM);
  assign dbg_own  = (state_q == S_HALTED) || (state_q == S_REG) || (state_q == S_MEM);
  assign mcu_rst  = (state_q == S_RST);

  assign rf_addr = addr_q[4:0];
  assign rf_wd   = din_q;
  assign rf_we   = (state_q == S_REG) && (cnt_q == 8'd0) && !acc_rd_q && (addr_q[4:0] != 5'd0);

  assign dm_addr = addr_q;
  assign dm_wd   = din_q;
  assign dm_be   = be_q;
  assign dm_re   = (state_q == S_MEM) && acc_rd_q;
  assign dm_we   = (state_q == S_MEM) && !acc_rd_q;

endmodule

// File: tb/tb_mcu_dbg_bridge.sv
// tb/tb_mcu_dbg_bridge.sv - directed self-checking bench for mcu_dbg_bridge
module tb_mcu_dbg_bridge;

  localparam logic [6:0] F_PAUSE  = 7'b1000000;
  localparam logic [6:0] F_RESUME = 7'b0100000;
  localparam logic [6:0] F_RESET  = 7'b0010000;
  localparam logic [6:0] F_REG_RD = 7'b0001000;
  localparam logic [6:0] F_REG_WR = 7'b0000100;
  localparam logic [6:0] F_MEM_RD = 7'b0000010;
  localparam logic [6:0] F_MEM_WR = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mcu_pc;
  logic        mcu_instr_done;
  logic        mcu_halt, mcu_rst, dbg_own;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd, rf_rdata;
  logic        rf_we;
  logic [31:0] dm_addr, dm_wd, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_re, dm_we, mem_ack;

  logic [31:0] rf [32];

  int n_tests = 0;
  int n_fail  = 0;

  int busy_cyc, rf_we_cnt, dm_re_cnt, dm_we_cnt, rst_cnt, halt_in_rst;
  logic        halt_first;
  logic [4:0]  rf_we_addr;
  logic [31:0] ack_addr;

  mcu_dbg_bridge_if cmd_if ();

  mcu_dbg_bridge #(.RST_CYCLES(4), .MEM_TIMEOUT(255)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd            (cmd_if),
    .mcu_pc         (mcu_pc),
    .mcu_instr_done (mcu_instr_done),
    .mcu_halt       (mcu_halt),
    .mcu_rst        (mcu_rst),
    .dbg_own        (dbg_own),
    .rf_addr        (rf_addr),
    .rf_wd          (rf_wd),
    .rf_we          (rf_we),
    .rf_rdata       (rf_rdata),
    .dm_addr        (dm_addr),
    .dm_wd          (dm_wd),
    .dm_be          (dm_be),
    .dm_re          (dm_re),
    .dm_we          (dm_we),
    .dm_rdata       (dm_rdata),
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  // Register file model; x0 deliberately holds a non-zero value so the bridge must force 0.
  assign rf_rdata = rf[rf_addr];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0100_0000 * i;
      rf[0] <= 32'hFFFF_FFFF;
      rf[7] <= 32'hA5A5_0007;
    end else if (rf_we) begin
      rf[rf_addr] <= rf_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command and follow it until busy drops, counting strobes on the way.
  task automatic do_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int done_at, input int ack_at);
    @(negedge clk);
    {cmd_if.pause, cmd_if.resume, cmd_if.reset, cmd_if.reg_rd,
     cmd_if.reg_wr, cmd_if.mem_rd, cmd_if.mem_wr} = f;
    cmd_if.addr   = a;
    cmd_if.d_in   = d;
    cmd_if.mem_be = be;
    cmd_if.valid  = 1'b1;
    @(negedge clk);
    cmd_if.valid = 1'b0;
    {cmd_if.pause, cmd_if.resume, cmd_if.reset, cmd_if.reg_rd,
     cmd_if.reg_wr, cmd_if.mem_rd, cmd_if.mem_wr} = 7'd0;
    busy_cyc = 0; rf_we_cnt = 0; dm_re_cnt = 0; dm_we_cnt = 0; rst_cnt = 0; halt_in_rst = 0;
    halt_first = 1'b0; rf_we_addr = 5'd0; ack_addr = 32'd0;
    while (cmd_if.mcu_busy && busy_cyc < 1000) begin
      busy_cyc++;
      if (busy_cyc == 1) halt_first = mcu_halt;
      if (rf_we) begin
        rf_we_cnt++;
        rf_we_addr = rf_addr;
      end
      if (dm_re) dm_re_cnt++;
      if (dm_we) dm_we_cnt++;
      if (mcu_rst) begin
        rst_cnt++;
        if (mcu_halt) halt_in_rst++;
      end
      mcu_instr_done = (busy_cyc == done_at);
      mem_ack        = (busy_cyc == ack_at);
      if (mem_ack) ack_addr = dm_addr;
      @(negedge clk);
    end
    mcu_instr_done = 1'b0;
    mem_ack        = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    mcu_pc         = 32'h0000_0080;
    mcu_instr_done = 1'b0;
    mem_ack        = 1'b0;
    dm_rdata       = 32'd0;
    cmd_if.valid   = 1'b0;
    cmd_if.d_in    = 32'd0;
    cmd_if.addr    = 32'd0;
    cmd_if.mem_be  = 4'd0;
    {cmd_if.pause, cmd_if.resume, cmd_if.reset, cmd_if.reg_rd,
     cmd_if.reg_wr, cmd_if.mem_rd, cmd_if.mem_wr} = 7'd0;

    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, cmd_if.mcu_busy}, 32'd0);
    check("rst_halt",  {31'd0, mcu_halt}, 32'd0);
    check("rst_own",   {31'd0, dbg_own}, 32'd0);
    check("rst_mrst",  {31'd0, mcu_rst}, 32'd0);
    check("rst_error", {31'd0, cmd_if.error}, 32'd0);
    check("rst_drd",   cmd_if.d_rd, 32'd0);
    check("rst_pc",    cmd_if.pc, 32'd0);
    check("rst_strb",  {29'd0, rf_we, dm_re, dm_we}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("pc_follow", cmd_if.pc, 32'h0000_0080);

    // Register access while the MCU runs
`ifdef DBG_AUTO_PAUSE_EN
    do_cmd(F_REG_RD, 32'd7, 32'd0, 4'd0, 2, 0);
    check("auto_busy",  busy_cyc, 4);
    check("auto_error", {31'd0, cmd_if.error}, 32'd0);
    check("auto_drd",   cmd_if.d_rd, 32'hA5A5_0007);
    check("auto_halt1", {31'd0, halt_first}, 32'd1);
    check("auto_run",   {30'd0, mcu_halt, dbg_own}, 32'd0);
`else
    do_cmd(F_REG_RD, 32'd7, 32'd0, 4'd0, 0, 0);
    check("run_rd_busy",  busy_cyc, 1);
    check("run_rd_error", {31'd0, cmd_if.error}, 32'd1);
    check("run_rd_halt",  {31'd0, mcu_halt}, 32'd0);
`endif

    do_cmd(F_RESUME, 32'd0, 32'd0, 4'd0, 0, 0);
    check("resume_run_busy",  busy_cyc, 1);
    check("resume_run_error", {31'd0, cmd_if.error}, 32'd0);

    do_cmd(F_PAUSE, 32'd0, 32'd0, 4'd0, 4, 0);
    check("pause_busy",  busy_cyc, 4);
    check("pause_halt1", {31'd0, halt_first}, 32'd1);
    check("pause_state", {30'd0, mcu_halt, dbg_own}, 32'd3);
    check("pause_error", {31'd0, cmd_if.error}, 32'd0);

    do_cmd(F_PAUSE, 32'd0, 32'd0, 4'd0, 0, 0);
    check("pause2_busy",  busy_cyc, 1);
    check("pause2_error", {31'd0, cmd_if.error}, 32'd0);

    do_cmd(F_REG_WR, 32'd5, 32'hDEAD_BEEF, 4'd0, 0, 0);
    check("regwr_busy",  busy_cyc, 2);
    check("regwr_we",    rf_we_cnt, 1);
    check("regwr_addr",  {27'd0, rf_we_addr}, 32'd5);
    check("regwr_error", {31'd0, cmd_if.error}, 32'd0);

    do_cmd(F_REG_RD, 32'd5, 32'd0, 4'd0, 0, 0);
    check("regrd_busy", busy_cyc, 2);
    check("regrd_drd",  cmd_if.d_rd, 32'hDEAD_BEEF);

    do_cmd(F_REG_WR, 32'd0, 32'h0000_1234, 4'd0, 0, 0);
    check("regwr0_we",    rf_we_cnt, 0);
    check("regwr0_error", {31'd0, cmd_if.error}, 32'd0);
    check("regwr0_busy",  busy_cyc, 2);

    do_cmd(F_REG_RD, 32'd0, 32'd0, 4'd0, 0, 0);
    check("regrd0_drd", cmd_if.d_rd, 32'd0);

    do_cmd(F_REG_RD, 32'h0000_0025, 32'd0, 4'd0, 0, 0);
    check("regidx_error", {31'd0, cmd_if.error}, 32'd1);
    check("regidx_busy",  busy_cyc, 1);

    dm_rdata = 32'h1234_5678;
    do_cmd(F_MEM_RD, 32'h0000_0100, 32'd0, 4'hF, 0, 7);
    check("memrd_drd",   cmd_if.d_rd, 32'h1234_5678);
    check("memrd_error", {31'd0, cmd_if.error}, 32'd0);
    check("memrd_busy",  busy_cyc, 7);
    check("memrd_re",    dm_re_cnt, 7);
    check("memrd_addr",  ack_addr, 32'h0000_0100);

    do_cmd(F_MEM_RD, 32'h0000_0102, 32'd0, 4'hF, 0, 1);
    check("misal_error", {31'd0, cmd_if.error}, 32'd1);
    check("misal_re",    dm_re_cnt, 0);
    check("misal_busy",  busy_cyc, 1);

    do_cmd(F_MEM_WR, 32'h0000_0102, 32'h0000_AAAA, 4'b1100, 0, 1);
    check("half_error", {31'd0, cmd_if.error}, 32'd0);
    check("half_we",    dm_we_cnt, 1);

    do_cmd(F_MEM_WR, 32'h0000_0100, 32'd0, 4'b0110, 0, 1);
    check("badbe_error", {31'd0, cmd_if.error}, 32'd1);
    check("badbe_we",    dm_we_cnt, 0);

    do_cmd(F_REG_RD | F_MEM_RD, 32'h0000_0100, 32'd0, 4'hF, 0, 1);
    check("multi_error", {31'd0, cmd_if.error}, 32'd1);
    check("multi_busy",  busy_cyc, 1);

    do_cmd(7'd0, 32'd0, 32'd0, 4'd0, 0, 0);
    check("none_error", {31'd0, cmd_if.error}, 32'd1);

    do_cmd(F_MEM_WR, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 0, 0);
    check("tmo_we",    dm_we_cnt, 255);
    check("tmo_busy",  busy_cyc, 255);
    check("tmo_error", {31'd0, cmd_if.error}, 32'd1);
    check("tmo_state", {30'd0, mcu_halt, dbg_own}, 32'd3);

    dm_rdata = 32'hCAFE_F00D;
    do_cmd(F_MEM_RD, 32'h0000_0204, 32'd0, 4'b0001, 0, 255);
    check("lastack_error", {31'd0, cmd_if.error}, 32'd0);
    check("lastack_drd",   cmd_if.d_rd, 32'hCAFE_F00D);

    do_cmd(F_RESUME, 32'd0, 32'd0, 4'd0, 0, 0);
    check("resume_busy",  busy_cyc, 1);
    check("resume_state", {30'd0, mcu_halt, dbg_own}, 32'd0);

    do_cmd(F_PAUSE, 32'd0, 32'd0, 4'd0, 1, 0);
    check("pause1_busy", busy_cyc, 1);

    do_cmd(F_RESET, 32'd0, 32'd0, 4'd0, 0, 0);
    check("rstcmd_len",   rst_cnt, 4);
    check("rstcmd_busy",  busy_cyc, 5);
    check("rstcmd_halt",  halt_in_rst, 0);
    check("rstcmd_state", {30'd0, mcu_halt, dbg_own}, 32'd0);
    check("rstcmd_error", {31'd0, cmd_if.error}, 32'd0);

    // Asynchronous reset while waiting on memory
    do_cmd(F_PAUSE, 32'd0, 32'd0, 4'd0, 2, 0);
    @(negedge clk);
    cmd_if.mem_rd = 1'b1;
    cmd_if.addr   = 32'h0000_0300;
    cmd_if.mem_be = 4'hF;
    cmd_if.valid  = 1'b1;
    @(negedge clk);
    cmd_if.valid  = 1'b0;
    cmd_if.mem_rd = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_re", {31'd0, dm_re}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_re",   {31'd0, dm_re}, 32'd0);
    check("arst_busy", {31'd0, cmd_if.mcu_busy}, 32'd0);
    check("arst_own",  {30'd0, dbg_own, mcu_rst}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_dbg_bridge.md
Name: mcu_dbg_bridge

Overview:
- Downstream stage of the debug controller: consumes its one-hot, `valid`-qualified command strobes and executes them against the Otter MCU.
- Commands are halt, resume, reset, register-file access and memory access.
- It owns the MCU stall request, the debug mux onto the RF and memory ports, and the reset pulse.
- It returns `mcu_busy`, `d_rd`, `error` and `pc` to the controller.

Parameters:
- RST_CYCLES, 4: width of the `mcu_rst` pulse in clocks (1..255).
- MEM_TIMEOUT, 255: max cycles to wait for `mem_ack` before aborting (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- d_in  in  32  write data from controller
- addr  in  32  RF index (bits 4:0) or memory byte address
- pause  in  1  halt command
- resume  in  1  resume command
- reset  in  1  MCU reset command
- reg_rd  in  1  RF read command
- reg_wr  in  1  RF write command
- mem_rd  in  1  memory read command
- mem_wr  in  1  memory write command
- mem_be  in  4  byte enables for memory access
- valid  in  1  single-cycle command strobe
- mcu_busy  out  1  command in progress
- d_rd  out  32  read result
- error  out  1  last command failed
- pc  out  32  registered copy of mcu_pc
- mcu_pc  in  32  MCU program counter
- mcu_instr_done  in  1  MCU retired an instruction this cycle (instruction boundary)
- mcu_halt  out  1  stall request to MCU
- mcu_rst  out  1  reset to MCU, active-high
- dbg_own  out  1  debug owns RF/memory ports (mux select)
- rf_addr  out  5  RF index
- rf_wd  out  32  RF write data
- rf_we  out  1  RF write enable
- rf_rdata  in  32  RF read data (combinational)
- dm_addr  out  32  memory address
- dm_wd  out  32  memory write data
- dm_be  out  4  memory byte enables
- dm_re  out  1  memory read request
- dm_we  out  1  memory write request
- dm_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory access complete

Behaviour:
- Reset values:
  - All outputs 0 except `mcu_halt`, which is 0 (MCU runs).
  - State RUN; `pc` = 0.
  - `reset_n` low mid-operation aborts immediately: all strobes deasserted, state RUN, no pulse on `mcu_rst`.
- Cycle timing and sampling:
  - `pc` is registered from `mcu_pc` every cycle.
  - `valid` is sampled only when `mcu_busy` = 0; `valid` while busy is ignored.
  - On acceptance, inputs are latched, `error` clears, and `mcu_busy` = 1 from the next cycle.
  - `mcu_busy` falls in the same cycle that `d_rd` and `error` take final values; both are then held until the next accepted command.
- Immediate errors (1-cycle busy, no side effects):
  - zero or more than one command flag set with `valid`;
  - reg/mem access while not halted;
  - reg access with `addr[31:5]` != 0;
  - memory access with `addr[1:0]` misaligned for `mem_be`:
    - legal `mem_be`: 4'b1111 requires `addr[1:0]` = 0;
    - 4'b0011 or 4'b1100 requires `addr[0]` = 0;
    - single-byte enables are always legal;
    - all other patterns are errors.
- States:
  - RUN → HALT_REQ on pause:
    - `mcu_halt` = 1 from the next cycle.
    - In HALT_REQ, the first `mcu_instr_done` moves the FSM to HALTED and busy falls.
    - pause while already HALTED completes in 1 cycle, no error.
  - HALTED → RUN on resume: `mcu_halt` and `dbg_own` = 0 next cycle; 1-cycle busy. resume in RUN completes in 1 cycle, no-op.
  - Any state → RST on reset:
    - `mcu_rst` = 1 for exactly RST_CYCLES cycles, then the FSM enters RUN.
    - `mcu_halt` is cleared.
    - busy falls the cycle after `mcu_rst` falls.
  - HALTED → REG on reg_rd/reg_wr:
    - `dbg_own` = 1, `rf_addr` = `addr[4:0]`, `rf_wd` = `d_in`.
    - `rf_we` pulses 1 cycle, except index 0, where it is suppressed with no error.
    - `d_rd` = `rf_rdata` (x0 reads 0).
    - Total busy: 2 cycles. Returns to HALTED.
  - HALTED → MEM on mem_rd/mem_wr:
    - `dbg_own` = 1; `dm_re`/`dm_we` held high until `mem_ack`.
    - On `mem_ack`, reads capture `dm_rdata` into `d_rd`, strobes drop, and the FSM returns to HALTED.
    - A counter starts at 0 on entry. Reaching MEM_TIMEOUT without ack: strobes drop, `error` = 1, return to HALTED.
    - `mem_ack` in the same cycle as the timeout counts as success.
- `dbg_own` = 1 in HALTED, REG and MEM; 0 otherwise.

Optional Feature:
- Macro: DBG_AUTO_PAUSE_EN.
- Defined:
  - Reg/mem access in RUN is not an error. The block enters HALT_REQ, performs the access once halted, then auto-resumes.
  - `mcu_busy` covers the entire sequence.
  - After a memory timeout, the block still resumes and sets `error`.
- Undefined: such access is an immediate error as above.

Test Plan:
- valid+pause in RUN; `mcu_instr_done` 3 cycles later → `mcu_halt` = 1 next cycle, busy high 4 cycles, state HALTED, `dbg_own` = 1.
- Halted; reg_wr addr = 5, d_in = 32'hDEADBEEF → one `rf_we` pulse, rf_addr = 5, busy 2 cycles; then reg_rd addr = 5 → d_rd = 32'hDEADBEEF. reg_wr addr = 0 → no `rf_we`, error = 0.
- Halted; mem_rd addr = 32'h100, be = 4'hF, ack after 7 cycles with 32'h12345678 → d_rd = 32'h12345678, error = 0. addr = 32'h102, be = 4'hF → error = 1, no `dm_re`.
- Halted; mem_wr with `mem_ack` never asserted, MEM_TIMEOUT = 255 → `dm_we` held 255 cycles, then error = 1, busy low, state HALTED.
- valid with reg_rd and mem_rd both set → error = 1, 1-cycle busy. reg_rd in RUN without DBG_AUTO_PAUSE_EN → error = 1; with it → halt, read, resume, error = 0.
- reset command during HALTED → `mcu_rst` high exactly 4 cycles, `mcu_halt` = 0, state RUN. `reset_n` low during MEM wait → `dm_re` = 0 and `mcu_busy` = 0 asynchronously.
